// File: rtl/adc_temp_sampler_if.sv
// ADC hard-block handshake plus the averaged result bus toward the display path.
interface adc_temp_sampler_if;
  logic        adc_eoc;
  logic [11:0] adc_dout;
  logic        adc_soc;
  logic [4:0]  adc_chsel;
  logic        adc_tsen;
  logic [11:0] sample;
  logic        sample_valid;
  logic [11:0] avg;
  logic        avg_valid;
  logic        timeout_err;

  // Sequencer side: drives the ADC controls and the results.
  modport master (
    input  adc_eoc, adc_dout,
    output adc_soc, adc_chsel, adc_tsen,
    output sample, sample_valid, avg, avg_valid, timeout_err
  );

  // ADC / consumer side.
  modport slave (
    output adc_eoc, adc_dout,
    input  adc_soc, adc_chsel, adc_tsen,
    input  sample, sample_valid, avg, avg_valid, timeout_err
  );
endinterface

// File: rtl/adc_temp_sampler.sv
// Temperature-sensor conversion sequencer with box-car averaging of 2^AVG_LOG2 samples.
module adc_temp_sampler #(
  parameter logic [4:0]  CHSEL    = 5'd17,
  parameter int unsigned AVG_LOG2 = 4,
  parameter int unsigned SETTLE   = 1000,
  parameter int unsigned INTERVAL = 50000,
  parameter int unsigned TIMEOUT  = 4096
) (
  input  logic                pll_clk,
  input  logic                rst_n,
  input  logic                enable,
  adc_temp_sampler_if.master  bus
);

  localparam int unsigned DATA_W  = 12;
  localparam int unsigned ACC_W   = DATA_W + AVG_LOG2;
  localparam int unsigned NS_W    = AVG_LOG2;
  localparam int unsigned MAX_A   = (SETTLE > INTERVAL) ? SETTLE : INTERVAL;
  localparam int unsigned CNT_MAX = (MAX_A > TIMEOUT) ? MAX_A : TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_GAP,
    S_CONV,
    S_CAPTURE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc;
  logic [NS_W-1:0]   nsamp;
  logic              stop;
  logic              enable_q;
  logic [2:0]        eoc_sync;
  logic              eoc_edge;
  logic              stopping;
  logic [ACC_W-1:0]  sum;

  // Channel select is a constant, valid even during reset.
  assign bus.adc_chsel = CHSEL;

  assign eoc_edge = eoc_sync[1] & ~eoc_sync[2];
  assign stopping = stop | ~enable;
  assign sum      = acc + ACC_W'(bus.adc_dout);

  // Bring adc_eoc into the pll_clk domain; third flop supplies the edge reference.
  always_ff @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      eoc_sync <= '0;
    end else begin
      eoc_sync <= {eoc_sync[1:0], bus.adc_eoc};
    end
  end

  // Sequencer FSM with registered ADC controls, capture and averaging.
  always_ff @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      cnt              <= '0;
      acc              <= '0;
      nsamp            <= '0;
      stop             <= 1'b0;
      enable_q         <= 1'b0;
      bus.adc_soc      <= 1'b0;
      bus.adc_tsen     <= 1'b0;
      bus.sample       <= '0;
      bus.sample_valid <= 1'b0;
      bus.avg          <= '0;
      bus.avg_valid    <= 1'b0;
      bus.timeout_err  <= 1'b0;
    end else begin
      bus.sample_valid <= 1'b0;
      bus.avg_valid    <= 1'b0;
      enable_q         <= enable;
      if (enable && !enable_q) begin
        bus.timeout_err <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          bus.adc_soc  <= 1'b0;
          bus.adc_tsen <= 1'b0;
          acc          <= '0;
          nsamp        <= '0;
          cnt          <= '0;
          stop         <= 1'b0;
          if (enable) begin
            bus.adc_tsen <= 1'b1;
            state        <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (!enable) begin
            bus.adc_tsen <= 1'b0;
            state        <= S_IDLE;
          end else if (cnt == CNT_W'(SETTLE - 1)) begin
            cnt         <= '0;
            bus.adc_soc <= 1'b1;
            state       <= S_CONV;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_GAP: begin
          if (!enable) begin
            bus.adc_tsen <= 1'b0;
            state        <= S_IDLE;
          end else if (cnt == CNT_W'(INTERVAL - 1)) begin
            cnt         <= '0;
            bus.adc_soc <= 1'b1;
            state       <= S_CONV;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_CONV: begin
          if (!enable) begin
            stop <= 1'b1;
          end
          // A capture on the final timeout cycle takes priority over the error.
          if (eoc_edge) begin
            bus.adc_soc      <= 1'b0;
            bus.sample       <= bus.adc_dout;
            bus.sample_valid <= 1'b1;
            cnt              <= '0;
            if (!stopping) begin
              if (nsamp == '1) begin
                bus.avg       <= sum[ACC_W-1:AVG_LOG2];
                bus.avg_valid <= 1'b1;
                acc           <= '0;
                nsamp         <= '0;
              end else begin
                acc   <= sum;
                nsamp <= nsamp + NS_W'(1);
              end
            end
            state <= S_CAPTURE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            bus.adc_soc     <= 1'b0;
            bus.timeout_err <= 1'b1;
            cnt             <= '0;
            if (stopping) begin
              bus.adc_tsen <= 1'b0;
              state        <= S_IDLE;
            end else begin
              state <= S_GAP;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_CAPTURE: begin
          cnt <= '0;
          if (stopping) begin
            bus.adc_tsen <= 1'b0;
            state        <= S_IDLE;
          end else begin
            state <= S_GAP;
          end
        end

        default: begin
          bus.adc_soc  <= 1'b0;
          bus.adc_tsen <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule
